// File: rtl/game_status_tx.sv
// UART transmitter for game status frames (FPGA -> MCU), 8N1, LSB first.
// Frame: HEADER, {Break, flag, Clear, 0, score}, seq, 8-bit checksum of the first three.
module game_status_tx #(
   parameter int         BAUD_DIV = 5208,
   parameter logic [7:0] HEADER   = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] score,
   input  logic       Break,
   input  logic       flag,
   input  logic       Clear,
   output logic       tx,
   output logic       tx_busy,
   output logic       frame_done,
   output logic [1:0] dbg_state
);

   // BAUD_DIV must be at least 4 for the bit timing to be meaningful.
   localparam int            CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] BIT_LAST = CW'(BAUD_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [1:0]      byte_idx_q, byte_idx_d;
   logic [3:0][7:0] frame_q, frame_d;
   logic [7:0]      seq_q, seq_d;
   logic            pending_q, pending_d;
   logic [3:0]      score_q, score_d;
   logic            Break_q, Break_d;
   logic            Clear_q, Clear_d;
   logic            tx_q, tx_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic            evt;
   logic            bit_end;
   logic            start_frame;
   logic [7:0]      byte1_now;
   logic [7:0]      csum_now;
   logic [7:0]      cur_byte;
   logic [2:0]      bit_nx;

   // Score changes in either direction; Break and Clear only on their rising edge.
   assign evt         = (score != score_q) | (Break & ~Break_q) | (Clear & ~Clear_q);
   assign bit_end     = (bit_cnt_q == BIT_LAST);
   assign start_frame = evt | pending_q;
   assign byte1_now   = {Break, flag, Clear, 1'b0, score};
   assign csum_now    = HEADER + byte1_now + seq_q;
   assign cur_byte    = frame_q[byte_idx_q];
   assign bit_nx      = bit_idx_q + 3'd1;

   // State register and all datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
         frame_q    <= '0;
         seq_q      <= '0;
         pending_q  <= 1'b0;
         score_q    <= '0;
         Break_q    <= 1'b0;
         Clear_q    <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         frame_q    <= frame_d;
         seq_q      <= seq_d;
         pending_q  <= pending_d;
         score_q    <= score_d;
         Break_q    <= Break_d;
         Clear_q    <= Clear_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_frame) state_d = START;
         START:   if (bit_end) state_d = DATA;
         DATA:    if (bit_end && (bit_idx_q == 3'd7)) state_d = STOP;
         STOP:    if (bit_end) state_d = (byte_idx_q == 2'd3) ? IDLE : START;
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      bit_cnt_d  = (state_q == IDLE || bit_end) ? '0 : bit_cnt_q + CW'(1);
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      frame_d    = frame_q;
      seq_d      = seq_q;
      pending_d  = pending_q;
      score_d    = score;
      Break_d    = Break;
      Clear_d    = Clear;
      tx_d       = tx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_frame) begin
               frame_d    = {csum_now, seq_q, byte1_now, HEADER};
               byte_idx_d = 2'd0;
               bit_idx_d  = 3'd0;
               tx_d       = 1'b0;
               busy_d     = 1'b1;
               pending_d  = 1'b0;
            end
         end
         START: begin
            pending_d = pending_q | evt;
            if (bit_end) begin
               bit_idx_d = 3'd0;
               tx_d      = cur_byte[0];
            end
         end
         DATA: begin
            pending_d = pending_q | evt;
            if (bit_end) begin
               if (bit_idx_q == 3'd7) begin
                  tx_d = 1'b1;
               end else begin
                  bit_idx_d = bit_nx;
                  tx_d      = cur_byte[bit_nx];
               end
            end
         end
         STOP: begin
            // An event on the final edge still lands in pending; the follow-up starts next edge.
            pending_d = pending_q | evt;
            if (bit_end) begin
               if (byte_idx_q == 2'd3) begin
                  busy_d = 1'b0;
                  done_d = 1'b1;
                  seq_d  = seq_q + 8'd1;
               end else begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  tx_d       = 1'b0;
               end
            end
         end
         default: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
         end
      endcase
   end

   assign tx         = tx_q;
   assign tx_busy    = busy_q;
   assign frame_done = done_q;
   assign dbg_state  = state_q;

endmodule

// File: doc/game_status_tx.md
Name: game_status_tx

Overview:
- UART transmitter that sends game status from the FPGA to the 52-series MCU.
- Carries the status produced by the ball-motion top: score, Break and flag.
- Runs in the opposite direction to the MCU-to-FPGA sensor path that delivers swing and pat_location.
- Sends one 4-byte frame, 8N1 and LSB first, whenever the score changes, a Break occurs or the game is cleared. The MCU uses these frames to drive its buzzer and segment display.

Parameters:
- BAUD_DIV, 5208: clocks per UART bit (50 MHz / 9600 baud); must be >= 4.
- HEADER, 8'hA5: first byte of every frame.

Ports:
- clk  in  1  system clock, 50 MHz main clock.
- rst_n  in  1  reset, synchronous and active-low.
- score  in  4  current score from the motion block.
- Break  in  1  ball-lost indication from the motion block.
- flag  in  1  ball-direction flag from the motion block.
- Clear  in  1  game clear / restart.
- tx  out  1  UART line to the MCU, idle high.
- tx_busy  out  1  high from the first start bit to the end of the last stop bit of a frame.
- frame_done  out  1  one-clock pulse at the end of the last stop bit.

Behaviour:
- Clock and reset:
  - Single clock clk; all state changes on the rising edge.
  - rst_n low at an edge sets: tx=1, tx_busy=0, frame_done=0, state=IDLE, seq=0, pending=0, and the input history registers to score_q=0, Break_q=0, Clear_q=0.
  - Reset mid-frame aborts the frame immediately: tx is high after that edge and no partial byte resumes.
- Event detection (registered history, updated every clock):
  - event = (score != score_q) | (Break & ~Break_q) | (Clear & ~Clear_q).
  - flag alone never triggers a frame.
  - Break held high triggers only once.
- FSM states are IDLE, START, DATA, STOP.
  - Bit counter bit_cnt is 0..BAUD_DIV-1. Bit index is 0..7. Byte index byte_idx is 0..3.
  - IDLE: on an edge with (event | pending):
    - go to START with byte_idx=0;
    - snapshot the frame bytes;
    - drive tx=0 and tx_busy=1 on that edge;
    - clear pending.
    - Latency: an input change is visible on tx one edge later.
  - START: tx=0 for BAUD_DIV clocks, then DATA.
  - DATA: each bit is held BAUD_DIV clocks, bit 0 first. After bit 7, go to STOP.
  - STOP: tx=1 for BAUD_DIV clocks. Then:
    - if byte_idx<3: byte_idx++ and go to START, with no idle gap between bytes;
    - else: IDLE, tx_busy=0, frame_done=1 for one clock, seq++ (8-bit, wraps 255->0).
  - Total frame length: 40*BAUD_DIV clocks.
- Frame contents (snapshotted at frame start; later input changes do not alter a frame in flight):
  - byte0 = HEADER.
  - byte1 = {Break, flag, Clear, 1'b0, score[3:0]}.
  - byte2 = seq.
  - byte3 = (byte0+byte1+byte2) mod 256.
- Events during a frame (tx_busy=1):
  - any event sets pending; several events collapse into one pending;
  - a single follow-up frame starts on the edge after frame_done, using values sampled at that edge.
- Simultaneous event and frame_done edge: the event sets pending, so the follow-up frame starts on the next edge.

Test Plan:
- Reset with BAUD_DIV=4, then hold all inputs constant for 500 clocks -> tx=1, tx_busy=0, no frame_done.
- score 0->3 with flag=1, Break=0, Clear=0 -> tx low on the next edge; bytes A5, 43, 00, E8, each bit 4 clocks, back to back; frame_done pulse at clock 160; tx_busy=0 afterwards.
- Break rises and stays high for 1000 clocks, with score=3 and flag=0 -> exactly one frame: A5, 83, 01, 29.
- score changes twice during a frame (3->4->5) -> exactly one follow-up frame, starting the edge after frame_done, with byte1 score=5 and seq incremented.
- Assert rst_n=0 during the DATA bit 3 of byte1 -> tx=1 and tx_busy=0 after that edge; the next frame after reset carries seq=00.
- Send 256 frames -> seq wraps from FF to 00; the checksum is correct on every frame.
